// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states and oversample constants.
// Imported by uart_fifo_core.
package uart_pkg;

  localparam int OVS = 16;
  localparam int MID = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_st_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO, power-of-two depth.
// Pointers carry one extra MSB to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_we;
  logic             w_re;

  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[AW] != r_rp[AW]) &&
                 (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_re  = pop && !empty;
  assign w_we  = push && (!full || w_re);
  assign dout  = empty ? '0 : r_mem[r_rp[AW-1:0]];

  // read/write pointers, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + (AW+1)'(1);
      if (w_re) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  // storage array; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX/RX FIFOs and echo mode.
// Define UART_PARITY_EN to add an even parity bit to both directions.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = 27000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 echo_en,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int         DIV     = INPUT_CLOCK / (OVS * BAUD_RATE);
  localparam int         DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] TK_END  = 4'(OVS - 1);
  localparam logic [3:0] TK_MID  = 4'(MID - 1);
  localparam logic [2:0] BIT_END = 3'(DATA_BITS - 1);
  localparam logic       STP_END = (STOP_BITS == 2);

  logic [DW-1:0]        r_div;
  logic                 w_tick;
  logic                 r_rx_s1, r_rx_s2;

  uart_st_e             r_rx_st, w_rx_st;
  logic [3:0]           r_rx_tk, w_rx_tk;
  logic [2:0]           r_rx_bit, w_rx_bit;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh;
  logic                 w_rx_end, w_rx_done;
  logic                 w_par_ok, w_good, w_dst_full;
  logic                 r_ferr, r_ovr;

  uart_st_e             r_tx_st, w_tx_st;
  logic [3:0]           r_tx_tk, w_tx_tk;
  logic [2:0]           r_tx_bit, w_tx_bit;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh;
  logic                 r_tx_stp, w_tx_stp;
  logic                 r_tx, w_tx;
  logic                 r_tx_avail, w_tx_end;

  logic                 w_rxf_push, w_rxf_full, w_rxf_empty;
  logic [DATA_BITS-1:0] w_rxf_dout;
  logic                 w_txf_push, w_txf_pop, w_txf_full, w_txf_empty;
  logic                 w_echo_push, w_user_push;
  logic [DATA_BITS-1:0] w_txf_din, w_txf_dout;

`ifdef UART_PARITY_EN
  logic                 r_rx_pb, w_rx_pb;
  logic                 r_tx_pb, w_tx_pb;
  logic                 r_perr;
`endif

  assign w_tick = (r_div == DW'(DIV - 1));

  // free-running oversample divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else        r_div <= w_tick ? '0 : r_div + DW'(1);
  end

  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx_end = w_tick && (r_rx_tk == TK_END);

  // receiver next-state
  always_comb begin
    w_rx_st   = r_rx_st;
    w_rx_tk   = r_rx_tk;
    w_rx_bit  = r_rx_bit;
    w_rx_sh   = r_rx_sh;
    w_rx_done = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_pb   = r_rx_pb;
`endif
    if (w_tick && r_rx_st != S_IDLE) w_rx_tk = r_rx_tk + 4'd1;
    unique case (r_rx_st)
      S_IDLE: begin
        if (!r_rx_s2) begin
          w_rx_st = S_START;
          w_rx_tk = '0;
        end
      end
      S_START: begin
        if (w_tick && r_rx_tk == TK_MID) begin
          w_rx_tk  = '0;
          w_rx_bit = '0;
          w_rx_st  = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_sh  = {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
          w_rx_bit = r_rx_bit + 3'd1;
          if (r_rx_bit == BIT_END) begin
`ifdef UART_PARITY_EN
            w_rx_st = S_PARITY;
`else
            w_rx_st = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_rx_end) begin
          w_rx_pb = r_rx_s2;
          w_rx_st = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_rx_end) begin
          w_rx_done = 1'b1;
          w_rx_st   = S_IDLE;
        end
      end
      default: w_rx_st = S_IDLE;
    endcase
  end

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st  <= S_IDLE;
      r_rx_tk  <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
`ifdef UART_PARITY_EN
      r_rx_pb  <= 1'b0;
`endif
    end else begin
      r_rx_st  <= w_rx_st;
      r_rx_tk  <= w_rx_tk;
      r_rx_bit <= w_rx_bit;
      r_rx_sh  <= w_rx_sh;
`ifdef UART_PARITY_EN
      r_rx_pb  <= w_rx_pb;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign w_par_ok = (r_rx_pb == ^r_rx_sh);
`else
  assign w_par_ok = 1'b1;
`endif
  assign w_good      = w_rx_done && r_rx_s2 && w_par_ok;
  assign w_dst_full  = echo_en ? w_txf_full : w_rxf_full;
  assign w_rxf_push  = w_good && !echo_en && !w_rxf_full;
  assign w_echo_push = w_good && echo_en && !w_txf_full;

  // one-cycle line-error and overrun pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr <= 1'b0;
`endif
    end else begin
      r_ferr <= w_rx_done && !r_rx_s2;
      r_ovr  <= w_good && w_dst_full;
`ifdef UART_PARITY_EN
      r_perr <= w_rx_done && r_rx_s2 && !w_par_ok;
`endif
    end
  end

  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
`ifdef UART_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign tx_ready    = !echo_en && !w_txf_full;
  assign w_user_push = tx_valid && tx_ready;
  assign w_txf_push  = w_echo_push || w_user_push;
  assign w_txf_din   = w_echo_push ? r_rx_sh : tx_data;
  assign w_tx_end    = w_tick && (r_tx_tk == TK_END);

  // transmitter next-state
  always_comb begin
    w_tx_st   = r_tx_st;
    w_tx_tk   = r_tx_tk;
    w_tx_bit  = r_tx_bit;
    w_tx_sh   = r_tx_sh;
    w_tx_stp  = r_tx_stp;
    w_tx      = r_tx;
    w_txf_pop = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_pb   = r_tx_pb;
`endif
    if (w_tick && r_tx_st != S_IDLE) w_tx_tk = r_tx_tk + 4'd1;
    unique case (r_tx_st)
      S_IDLE: begin
        if (w_tick && r_tx_avail && !w_txf_empty) begin
          w_txf_pop = 1'b1;
          w_tx_sh   = w_txf_dout;
          w_tx_tk   = '0;
          w_tx      = 1'b0;
          w_tx_st   = S_START;
`ifdef UART_PARITY_EN
          w_tx_pb   = ^w_txf_dout;
`endif
        end
      end
      S_START: begin
        if (w_tx_end) begin
          w_tx_bit = '0;
          w_tx     = r_tx_sh[0];
          w_tx_st  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tx_end) begin
          w_tx_bit = r_tx_bit + 3'd1;
          w_tx_sh  = r_tx_sh >> 1;
          if (r_tx_bit == BIT_END) begin
`ifdef UART_PARITY_EN
            w_tx    = r_tx_pb;
            w_tx_st = S_PARITY;
`else
            w_tx     = 1'b1;
            w_tx_stp = 1'b0;
            w_tx_st  = S_STOP;
`endif
          end else begin
            w_tx = r_tx_sh[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_tx_end) begin
          w_tx     = 1'b1;
          w_tx_stp = 1'b0;
          w_tx_st  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tx_end) begin
          if (r_tx_stp == STP_END) w_tx_st = S_IDLE;
          else                     w_tx_stp = 1'b1;
        end
      end
      default: w_tx_st = S_IDLE;
    endcase
  end

  // transmitter state register; line idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st    <= S_IDLE;
      r_tx_tk    <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_stp   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_avail <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_pb    <= 1'b0;
`endif
    end else begin
      r_tx_st    <= w_tx_st;
      r_tx_tk    <= w_tx_tk;
      r_tx_bit   <= w_tx_bit;
      r_tx_sh    <= w_tx_sh;
      r_tx_stp   <= w_tx_stp;
      r_tx       <= w_tx;
      r_tx_avail <= !w_txf_empty;
`ifdef UART_PARITY_EN
      r_tx_pb    <= w_tx_pb;
`endif
    end
  end

  assign tx       = r_tx;
  assign rx_valid = !w_rxf_empty;
  assign rx_data  = w_rxf_dout;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_txf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_txf_push),
    .pop   (w_txf_pop),
    .din   (w_txf_din),
    .dout  (w_txf_dout),
    .full  (w_txf_full),
    .empty (w_txf_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rxf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_rxf_push),
    .pop   (rx_ready),
    .din   (r_rx_sh),
    .dout  (w_rxf_dout),
    .full  (w_rxf_full),
    .empty (w_rxf_empty)
  );

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: table-driven and scoreboard bench for uart_fifo_core.
// 16 clocks per bit; byte queues hold the expected RX pops and TX frames.
module tb_uart_fifo_core;

  logic       clk = 1'b0;
  logic       rst_n, rx, tx;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, echo_en;
  logic       frame_err, parity_err, overrun;
  logic [7:0] tx_data, rx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr = 0;
  int n_txlow = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  typedef struct {
    logic [7:0] d;
    logic       sb;
    logic       glitch;
    logic       push;
    logic       ferr;
  } vec_t;
  vec_t vt[5];

  logic [7:0] b, e;
  logic       sb, pb;
  bit         ok, sdone;
  int         f0, o0, t0, nw;

  always #5 clk = ~clk;

  uart_fifo_core #(
    .INPUT_CLOCK (1600000),
    .BAUD_RATE   (100000),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .tx         (tx),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .echo_en    (echo_en),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always @(negedge clk) begin
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (overrun)    n_ovr++;
    if (tx == 1'b0) n_txlow++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = ^d;
    repeat (16) @(negedge clk);
`endif
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic cap_tx(output logic [7:0] cb, output logic csb,
                        output logic cpb, output bit cok);
    int n;
    n = 0;
    cb = '0;
    csb = 1'b0;
    cpb = 1'b0;
    cok = 1'b0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    repeat (8) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      cb[i] = tx;
    end
`ifdef UART_PARITY_EN
    repeat (16) @(negedge clk);
    cpb = tx;
`endif
    repeat (16) @(negedge clk);
    csb = tx;
    cok = 1'b1;
  endtask

  task automatic pop_chk(input string nm);
    logic [7:0] x;
    x = rxq.pop_front();
    chk($sformatf("%s_valid", nm), 32'(rx_valid), 32'd1);
    chk($sformatf("%s_data", nm), 32'(rx_data), 32'(x));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    rx       = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    echo_en  = 1'b0;
    vt[0] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    txq.push_back(8'hA5);
    chk("tx_ready_w0", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_data = 8'h3C;
    txq.push_back(8'h3C);
    chk("tx_ready_w1", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (2) begin
      cap_tx(b, sb, pb, ok);
      e = txq.pop_front();
      chk("tx_frame_seen", 32'(ok), 32'd1);
      chk("tx_byte", 32'(b), 32'(e));
      chk("tx_stop", 32'(sb), 32'd1);
    end
    chk("tx_ready_after", 32'(tx_ready), 32'd1);
    repeat (20) @(negedge clk);

    foreach (vt[i]) begin
      f0 = n_ferr;
      o0 = n_ovr;
      if (vt[i].push) rxq.push_back(vt[i].d);
      if (vt[i].glitch) begin
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
      end else begin
        send_rx(vt[i].d, vt[i].sb);
      end
      chk($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vt[i].ferr));
      chk($sformatf("vec%0d_ovr", i), 32'(n_ovr - o0), 32'd0);
    end
    chk("burst_rx_valid", 32'(rx_valid), 32'd1);
    while (rxq.size() > 0) pop_chk("burst");
    chk("burst_drained", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 17; i++) begin
      o0 = n_ovr;
      if (i < 16) rxq.push_back(8'(32'h20 + i));
      send_rx(8'(32'h20 + i), 1'b1);
      chk($sformatf("ovr_f%0d", i), 32'(n_ovr - o0),
          (i == 16) ? 32'd1 : 32'd0);
    end
    chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
    while (rxq.size() > 0) pop_chk("ovr");
    chk("ovr_drained", 32'(rx_valid), 32'd0);

    echo_en = 1'b1;
    @(negedge clk);
    chk("echo_tx_ready", 32'(tx_ready), 32'd0);
    txq.push_back(8'h55);
    fork
      send_rx(8'h55, 1'b1);
      cap_tx(b, sb, pb, ok);
    join
    e = txq.pop_front();
    chk("echo_frame_seen", 32'(ok), 32'd1);
    chk("echo_byte", 32'(b), 32'(e));
    chk("echo_stop", 32'(sb), 32'd1);
    chk("echo_rx_valid", 32'(rx_valid), 32'd0);
    chk("echo_tx_ready2", 32'(tx_ready), 32'd0);
    repeat (20) @(negedge clk);

    sdone = 1'b0;
    fork
      begin
        send_rx(8'hA0, 1'b1);
        sdone = 1'b1;
      end
      begin
        nw = 0;
        while (tx !== 1'b0 && nw < 400) begin
          @(negedge clk);
          nw++;
        end
        chk("echo2_started", 32'(tx), 32'd0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_tx_async", 32'(tx), 32'd1);
        while (!sdone) @(negedge clk);
      end
    join
    echo_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    rst_n = 1'b1;
    t0 = n_txlow;
    repeat (300) @(negedge clk);
    chk("post_rst_tx_idle", 32'(n_txlow - t0), 32'd0);
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("total_ferr", 32'(n_ferr), 32'd1);
    chk("total_perr", 32'(n_perr), 32'd0);

`ifdef UART_PARITY_EN
    tx_valid = 1'b1;
    tx_data  = 8'h07;
    txq.push_back(8'h07);
    @(negedge clk);
    tx_valid = 1'b0;
    cap_tx(b, sb, pb, ok);
    e = txq.pop_front();
    chk("par_tx_byte", 32'(b), 32'(e));
    chk("par_tx_bit", 32'(pb), 32'd1);
    f0 = n_perr;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    e = 8'h07;
    for (int i = 0; i < 8; i++) begin
      rx = e[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (36) @(negedge clk);
    chk("par_rx_err", 32'(n_perr - f0), 32'd1);
    chk("par_rx_nopush", 32'(rx_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Full-duplex UART with parametrised frame format, 16x-oversampled receiver and TX/RX FIFOs behind a valid/ready byte interface. It succeeds the single-byte echo top: it buffers bursts in both directions, reports line errors, and retains echo as a run-time mode. It sits between the board `rx`/`tx` pins and any on-chip consumer, such as a command parser or a debug bridge.

## Interface
- `INPUT_CLOCK`, 27000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate. The oversample divisor is `INPUT_CLOCK/(16*BAUD_RATE)`, rounded down, and must be ≥1.
- `DATA_BITS`, 8: payload bits per frame, 5–8.
- `STOP_BITS`, 1: stop bits sent, 1 or 2. The receiver checks only the first stop bit.
- `FIFO_DEPTH`, 16: entries per FIFO, a power of two ≥2.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `rx` input 1: serial in, asynchronous to `clk`, idles high.
- `tx` output 1: serial out, idles high.
- `tx_data` input DATA_BITS: byte to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: TX FIFO can accept a byte.
- `rx_data` output DATA_BITS: head of the RX FIFO.
- `rx_valid` output 1: RX FIFO is not empty.
- `rx_ready` input 1: consumer pops the head byte.
- `echo_en` input 1: received bytes are routed into the TX FIFO instead of the RX FIFO.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `parity_err` output 1: one-cycle pulse on a parity mismatch. It is tied 0 without the macro.
- `overrun` output 1: one-cycle pulse when a received byte is dropped because the destination FIFO is full.

## Operation
- **Tick generator:** a free-running counter produces `tick16`, a one-cycle pulse every divisor clocks.
- **RX synchroniser:** 2-flop synchroniser on `rx`, reset value 1.
- **RX FSM states:** IDLE → START → DATA → PARITY (macro only) → STOP → IDLE.
  - IDLE: on sampled `rx`==0, clear the tick count and enter START.
  - START: at the 8th tick, re-sample `rx`. If high, the start was false; return to IDLE with no error. If low, enter DATA.
  - DATA: every 16 ticks, sample one bit into a shift register, LSB first. After DATA_BITS samples, go to PARITY or STOP.
  - STOP: at 16 ticks, sample the stop bit.
    - If the stop bit is 1 and parity is good: push the byte.
    - If the stop bit is 0: pulse `frame_err`, drop the byte, and go to IDLE immediately, without waiting for the line to go high.
    - If parity is bad: pulse `parity_err` and drop the byte.
- **RX push destination:** the RX FIFO when `echo_en`=0; the TX FIFO when `echo_en`=1.
  - If the destination is full, pulse `overrun` and drop the byte. FIFO contents are untouched.
- **Echo mode:** while `echo_en`=1, `tx_ready` is forced to 0 and user writes are ignored. If an RX push and a user write target the TX FIFO in the same cycle, the RX push wins.
- **TX FSM states:** IDLE → START → DATA → PARITY (macro only) → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty, pop the head on the next `tick16` and drive the start bit.
  - Every bit lasts exactly 16 ticks. Data is sent LSB first, followed by STOP_BITS ones.
  - The FSM re-checks the FIFO in IDLE only, so there is no gap-free back-to-back guarantee. The gap between frames is ≤1 tick period.
- **FIFOs:** first-word fall-through. Pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty, and pointers wrap naturally.
  - A simultaneous push and pop on a full FIFO is allowed: count is unchanged.
  - A simultaneous push and pop on an empty FIFO: the push lands and the pop is ignored, because `rx_valid` was 0.
- **`echo_en` changes:** take effect at the next push decision. A frame already in flight completes unchanged.

## Timing
- **Reset values:** `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `frame_err`=`parity_err`=`overrun`=0. Both FSMs are in IDLE, both FIFOs are empty, and the tick counter is 0.
- **Reset mid-frame:** abandons the frame. `tx` returns high asynchronously and all FIFO contents are lost.
- **TX write:** handshake when `tx_valid`&&`tx_ready` at edge N. `tx` goes low at the first `tick16` at or after N+2.
- **RX write:** a byte appears on `rx_valid` one cycle after the STOP sample edge.
- **RX pop:** `rx_valid`&&`rx_ready` at edge N pops the head. The next head, or `rx_valid`=0, is visible at N+1.
- **RX latency:** from the `rx` falling edge to the STOP sample is (1.5+DATA_BITS[+1])×16 ticks, plus 2–3 cycles of synchroniser and edge detection.
- **Error pulses:** exactly one cycle wide, coincident with the STOP-sample decision.

## Configuration
- **`UART_PARITY_EN` defined:** both FSMs include the PARITY state.
  - Even parity is sent after the data bits.
  - The received parity bit is checked; a mismatch pulses `parity_err` and drops the byte.
- **`UART_PARITY_EN` undefined:** no parity bit is sent or expected, and `parity_err` is constant 0.

## Structure
- **Package `uart_pkg`:** RX/TX state enumeration, and the oversample constant 16 with its mid-point value 8.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH; async active-low reset; ports for push, pop, din, dout, full and empty. It is instantiated twice, for TX and RX.
- **In `uart_fifo_core`:** tick generator, both FSMs and the echo mux stay in the top.

## Test plan
Bench settings: INPUT_CLOCK=1600000, BAUD_RATE=100000 (divisor 1, 16 clocks per bit).
- **TX sequence:** write 0xA5 then 0x3C back-to-back → `tx` shows 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, each bit 16 clocks; `tx_ready` stays 1.
- **RX burst and pop:** drive three frames 0x01, 0x80, 0xFF on `rx` with `rx_ready`=0 → `rx_valid`=1; pop order is 0x01, 0x80, 0xFF; `rx_valid` drops to 0 one cycle after the third pop.
- **Overrun:** send FIFO_DEPTH+1 frames with no pops → `overrun` pulses once, on the last frame; the FIFO holds the first 16 bytes.
- **Line errors:** a frame with the stop bit 0 → `frame_err` pulses and no push. A 4-clock low glitch on idle `rx` → no error and no push.
- **Echo and reset:** `echo_en`=1, receive 0x55 → 0x55 is retransmitted on `tx`, `rx_valid` stays 0, and `tx_ready`=0. Then assert `rst_n` low mid-echo → `tx`=1 immediately and both FIFOs are empty.
- **Parity (with `UART_PARITY_EN`):** 0x07 is sent with parity bit 1. A received 0x07 with parity bit 0 → `parity_err` pulses and no push.
